dsp_result_collector: RTL and testbench
=======================================

# dsp_result_collector

Captures results leaving the DSP48A1 slice and turns them into a buffered valid/ready stream. The issuing logic marks each operand set presented to the DSP with `IN_VALID`. The collector tracks those operand sets through the DSP's fixed pipeline latency, honouring the shared `CE`. It samples `P`/`CARRYOUTF` when each tagged result emerges and queues the results for a downstream consumer. It sits directly after the `DSP` instance, on the opposite side from operand issue, and throttles issue through credits.

## Interface
- `P_WIDTH`, 48: width of `P`/`OUT_DATA`.
- `LATENCY`, 4: cycles from operand capture to valid `P` (default DSP config: DREG, B1REG, MREG, PREG); legal range 1..8.
- `DEPTH`, 8: result FIFO entries, power of two, 2..32.

- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset of all state.
- `CE` in 1: same clock enable as driven to the DSP pipeline registers.
- `IN_VALID` in 1: operand set presented to DSP this cycle.
- `ISSUE_READY` out 1: credit available; issue permitted.
- `P` in P_WIDTH: DSP P output.
- `CARRYOUTF` in 1: DSP fabric carry-out.
- `OUT_DATA` out P_WIDTH: head result.
- `OUT_CARRY` out 1: head carry.
- `OUT_VALID` out 1: head entry valid.
- `OUT_READY` in 1: consumer accepts head.
- `COUNT` out $clog2(DEPTH)+1: entries stored in the FIFO.
- `OVERFLOW` out 1: sticky; an issue was attempted without credit.

## Operation
- Issue accepted = `IN_VALID & CE & ISSUE_READY`. `IN_VALID` while `CE`=0 is ignored: the DSP does not capture the operands, no tag is created, and no error is raised.
- Tag pipeline: a LATENCY-bit shift register. It advances only when `CE`=1, and bit 0 is loaded with issue accepted.
- Capture: when `CE`=1 and the last tag bit is 1, {`CARRYOUTF`,`P`} is pushed into the FIFO. While `CE`=0, the tags and `P` both freeze, so no duplicate capture occurs.
- Credits: `inflight` is the number of set tag bits. `ISSUE_READY` = (`inflight` + `COUNT`) < `DEPTH`. This guarantees a push never meets a full FIFO; the bench asserts that condition.
- `IN_VALID & CE & !ISSUE_READY` sets `OVERFLOW`. The issue is dropped: no tag is created. `OVERFLOW` is cleared only by `RST`.
- Pop = `OUT_VALID & OUT_READY`. Push and pop in the same cycle are both performed and `COUNT` is unchanged. Pop does not depend on `CE`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `COUNT` distinguishes full from empty.
- `OUT_DATA`/`OUT_CARRY` are read combinationally from the head entry (first-word fall-through). They show 0 when empty after reset.

## Timing
- Reset values: `OUT_VALID`=0, `OUT_DATA`=0, `OUT_CARRY`=0, `COUNT`=0, `OVERFLOW`=0, `ISSUE_READY`=1. Tags, pointers and memory are cleared.
- An issue at edge N with `CE` held at 1 yields a result on `P` after edge N+LATENCY-1. That result is captured at edge N+LATENCY, and `OUT_VALID` rises after edge N+LATENCY if the FIFO was empty.
- Each cycle with `CE`=0 adds one cycle of latency.
- `ISSUE_READY` is combinational from registered state only; there is no path from `IN_VALID` or `OUT_READY`.
- `RST` mid-operation discards in-flight tags and queued results. Issue resumes on the cycle after `RST` deasserts.
- Throughput: one result per cycle sustained when `OUT_READY`=1 and `CE`=1.

## Configuration
- `DSP_COLLECT_CARRY_EN` defined: FIFO entries are P_WIDTH+1 bits and `OUT_CARRY` follows the captured `CARRYOUTF`.
- `DSP_COLLECT_CARRY_EN` not defined: entries are P_WIDTH bits, `CARRYOUTF` is unused, and `OUT_CARRY` is tied to 0.

## Structure
- Shared package `dsp_pkg` holds:
  - DSP width constants: P 48, A/B/D/BCIN 18, C/PCIN 48, M 36.
  - OPMODE bit-position localparams: X mux [1:0], Z mux [3:2], pre-adder enable [4], carry-in [5], pre-sub [6], post-sub [7].
  - The default pipeline latency constant, used as the `LATENCY` default.
- One sub-module, `dsp_sync_fifo`: a parameterised width/depth FWFT FIFO with synchronous active-high reset and a count output. The collector contains the tag pipeline, credit logic and `OVERFLOW`.

## Test plan
- Reset: hold `RST` 3 cycles with `IN_VALID`=1 -> `OUT_VALID`=0, `COUNT`=0, `ISSUE_READY`=1, and no tags afterward.
- Latency: `CE`=1; issue A=3,B=2,D=4,C=5 with OPMODE 8'b00011101 -> `OUT_DATA`=23 with `OUT_VALID` rising exactly 4 edges after issue.
- CE stall: issue, then drop `CE` for 5 cycles mid-flight -> exactly one entry, `OUT_VALID` 9 edges after issue, value unchanged.
- Backpressure: `OUT_READY`=0 and issue every cycle -> exactly 8 issues accepted, `ISSUE_READY`=0, `COUNT` reaches 8. An attempted 9th issue sets `OVERFLOW`=1 with `COUNT` still 8.
- Drain with wrap: from full, `OUT_READY`=1 while issuing continuously for 20 cycles -> results emerge in issue order with no loss or duplication, and pointers wrap twice.
- Carry (`DSP_COLLECT_CARRY_EN` defined): PCIN=48'hFFFFFFFFFFFF, OPMODE 8'b00110100 -> `OUT_DATA`=0, `OUT_CARRY`=1.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP48A1 constants: port widths, OPMODE field positions and default pipeline latency.
package dsp_pkg;

  localparam int DSP_P_W    = 48;
  localparam int DSP_A_W    = 18;
  localparam int DSP_B_W    = 18;
  localparam int DSP_D_W    = 18;
  localparam int DSP_BCIN_W = 18;
  localparam int DSP_C_W    = 48;
  localparam int DSP_PCIN_W = 48;
  localparam int DSP_M_W    = 36;

  localparam int OPM_X_LSB       = 0;
  localparam int OPM_X_MSB       = 1;
  localparam int OPM_Z_LSB       = 2;
  localparam int OPM_Z_MSB       = 3;
  localparam int OPM_PREADD_BIT  = 4;
  localparam int OPM_CARRYIN_BIT = 5;
  localparam int OPM_PRESUB_BIT  = 6;
  localparam int OPM_POSTSUB_BIT = 7;

  // DREG, B1REG, MREG and PREG enabled
  localparam int DSP_DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    OPM_X_ZERO = 2'b00,
    OPM_X_M    = 2'b01,
    OPM_X_P    = 2'b10,
    OPM_X_DAB  = 2'b11
  } opm_x_e;

  typedef enum logic [1:0] {
    OPM_Z_ZERO = 2'b00,
    OPM_Z_PCIN = 2'b01,
    OPM_Z_P    = 2'b10,
    OPM_Z_C    = 2'b11
  } opm_z_e;

endpackage

// File: rtl/dsp_sync_fifo.sv
// First-word fall-through FIFO with synchronous active-high reset; head is read combinationally.
module dsp_sync_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle
    push_ok  = push && ((count_q != (AW+1)'(DEPTH)) || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (srst) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/dsp_result_collector.sv
// Tracks tagged operand sets through the DSP pipeline and queues P results behind a credit-gated issue port.
// Optional feature macro: DSP_COLLECT_CARRY_EN stores CARRYOUTF alongside each result.
module dsp_result_collector
  import dsp_pkg::*;
#(
  parameter int P_WIDTH = DSP_P_W,
  parameter int LATENCY = DSP_DEFAULT_LATENCY,
  parameter int DEPTH   = 8,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               IN_VALID,
  output logic               ISSUE_READY,
  input  logic [P_WIDTH-1:0] P,
  input  logic               CARRYOUTF,
  output logic [P_WIDTH-1:0] OUT_DATA,
  output logic               OUT_CARRY,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [CW-1:0]      COUNT,
  output logic               OVERFLOW
);

`ifdef DSP_COLLECT_CARRY_EN
  localparam int ENTRY_W = P_WIDTH + 1;
`else
  localparam int ENTRY_W = P_WIDTH;
`endif

  logic [LATENCY-1:0] tag_q, tag_d;
  logic               overflow_q, overflow_d;
  logic [3:0]         inflight;
  logic [6:0]         credit_sum;
  logic               issue_ok;
  logic               issue_acc;
  logic               capture;
  logic               pop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic               head_valid;
  logic [CW-1:0]      fifo_count;

  // Credits cover both queued entries and results still inside the DSP,
  // so a capture can never find the FIFO full.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + 4'(tag_q[i]);
    end
    credit_sum = 7'(inflight) + 7'(fifo_count);
    issue_ok   = (credit_sum < 7'(DEPTH));
  end

  always_comb begin
    issue_acc  = IN_VALID && CE && issue_ok;
    capture    = CE && tag_q[LATENCY-1];
    overflow_d = overflow_q || (IN_VALID && CE && !issue_ok);
    pop        = head_valid && OUT_READY;
  end

  generate
    if (LATENCY == 1) begin : g_tag_one
      always_comb begin
        tag_d = CE ? issue_acc : tag_q;
      end
    end else begin : g_tag_shift
      always_comb begin
        tag_d = CE ? {tag_q[LATENCY-2:0], issue_acc} : tag_q;
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef DSP_COLLECT_CARRY_EN
  assign push_data = {CARRYOUTF, P};
  assign OUT_CARRY = head_data[P_WIDTH];
`else
  logic unused_carryoutf;
  assign unused_carryoutf = CARRYOUTF;
  assign push_data        = P;
  assign OUT_CARRY        = 1'b0;
`endif

  dsp_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .srst       (RST),
    .push       (capture),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign OUT_DATA    = head_data[P_WIDTH-1:0];
  assign OUT_VALID   = head_valid;
  assign COUNT       = fifo_count;
  assign ISSUE_READY = issue_ok;
  assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_dsp_result_collector.sv
// Self-checking bench: behavioural DSP48A1 model feeding the collector, table vectors plus a result scoreboard.
module tb_dsp_result_collector;
  import dsp_pkg::*;

  localparam int PW    = 48;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          issue_ready;
  logic [PW-1:0] p;
  logic          carryoutf;
  logic [PW-1:0] out_data;
  logic          out_carry;
  logic          out_valid;
  logic [3:0]    count;
  logic          overflow;

  dsp_result_collector #(.P_WIDTH(PW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .ISSUE_READY(issue_ready),
    .P(p), .CARRYOUTF(carryoutf), .OUT_DATA(out_data), .OUT_CARRY(out_carry),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .COUNT(count), .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  // Operands presented to the modelled DSP
  logic [17:0] a_v = '0, b_v = '0, d_v = '0;
  logic [47:0] c_v = '0, pcin_v = '0;
  logic [7:0]  op_v = '0;

  function automatic logic [48:0] dsp_calc(logic [17:0] a, logic [17:0] b, logic [17:0] d,
                                           logic [47:0] c, logic [47:0] pcin, logic [7:0] op);
    logic [17:0] pre;
    logic [17:0] mb;
    logic [35:0] m;
    logic [47:0] x, z;
    logic [48:0] cin;
    pre = op[OPM_PRESUB_BIT] ? (d - b) : (d + b);
    mb  = op[OPM_PREADD_BIT] ? pre : b;
    m   = 36'(a) * 36'(mb);
    case (op[OPM_X_MSB:OPM_X_LSB])
      2'b01:   x = {12'b0, m};
      2'b11:   x = {d[11:0], a, b};
      default: x = '0;
    endcase
    case (op[OPM_Z_MSB:OPM_Z_LSB])
      2'b01:   z = pcin;
      2'b11:   z = c;
      default: z = '0;
    endcase
    cin = 49'(op[OPM_CARRYIN_BIT]);
    if (op[OPM_POSTSUB_BIT]) return {1'b0, z} - ({1'b0, x} + cin);
    return {1'b0, z} + {1'b0, x} + cin;
  endfunction

  logic [48:0] pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (ce) begin
      pipe[0] <= dsp_calc(a_v, b_v, d_v, c_v, pcin_v, op_v);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign p         = pipe[LAT-1][47:0];
  assign carryoutf = pipe[LAT-1][48];

  // Transaction-level reference state
  bit          m_tags [LAT];
  int          m_count = 0;
  bit          m_ovf = 0;
  logic [48:0] exp_q [$];
  int          tests = 0, fails = 0;
  int          n_acc = 0, n_pop = 0;

  function automatic bit m_ready();
    int inflight = 0;
    for (int i = 0; i < LAT; i++) inflight += int'(m_tags[i]);
    return (inflight + m_count) < DEPTH;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(bit iv, bit ce_i, bit ordy, bit rst_i);
    bit pop, acc, cap;
    logic [48:0] e;
    in_valid  = iv;
    ce        = ce_i;
    out_ready = ordy;
    rst       = rst_i;
    #1;
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) m_tags[i] = 0;
      m_count = 0;
      m_ovf   = 0;
      exp_q.delete();
    end else begin
      pop = (m_count > 0) && ordy;
      if (pop) begin
        check("pop_data", 64'(out_data), 64'(exp_q[0][47:0]));
        check("pop_carry", 64'(out_carry), 64'(exp_q[0][48]));
        $display("[TB] pop #%0d data=%0h carry=%0b", n_pop, out_data, out_carry);
        void'(exp_q.pop_front());
        n_pop++;
      end
      acc = iv && ce_i && m_ready();
      if (iv && ce_i && !m_ready()) m_ovf = 1;
      cap = ce_i && m_tags[LAT-1];
      if (cap) check("push_room", 64'((count < 4'(DEPTH)) || (out_valid && ordy)), 64'd1);
      if (ce_i) begin
        for (int i = LAT-1; i > 0; i--) m_tags[i] = m_tags[i-1];
        m_tags[0] = acc;
      end
      m_count = m_count + int'(cap) - int'(pop);
      if (acc) begin
        e = dsp_calc(a_v, b_v, d_v, c_v, pcin_v, op_v);
`ifndef DSP_COLLECT_CARRY_EN
        e[48] = 1'b0;
`endif
        exp_q.push_back(e);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    check("count", 64'(count), 64'(m_count));
    check("out_valid", 64'(out_valid), 64'(m_count != 0));
    check("issue_ready", 64'(issue_ready), 64'(m_ready()));
    check("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic set_ops(bit on);
    a_v = on ? 18'd3 : '0;
    b_v = on ? 18'd2 : '0;
    d_v = on ? 18'd4 : '0;
    c_v = on ? 48'd5 : '0;
    pcin_v = '0;
    op_v = on ? 8'b00011101 : 8'h00;
  endtask

  task automatic set_rand_ops();
    a_v = 18'($urandom_range(0, 1000));
    b_v = 18'($urandom_range(0, 1000));
    d_v = 18'($urandom_range(0, 1000));
    c_v = 48'($urandom_range(0, 100000));
    pcin_v = '0;
    op_v = 8'b00011101;
  endtask

  typedef struct {
    bit      iv;
    bit      ce;
    bit      ordy;
    bit      ops;
    bit      exp_valid;
    int      exp_data;
    int      exp_count;
  } vec_t;

  vec_t lat_tbl [6];
  vec_t stall_tbl [12];

  task automatic apply(vec_t v, string name);
    set_ops(v.ops);
    tick(v.iv, v.ce, v.ordy, 1'b0);
    check({name, "_valid"}, 64'(out_valid), 64'(v.exp_valid));
    check({name, "_count"}, 64'(count), 64'(v.exp_count));
    if (v.exp_valid) check({name, "_data"}, 64'(out_data), 64'(v.exp_data));
  endtask

  initial begin
    int acc_seen;
    int budget;

    lat_tbl[0] = '{1, 1, 0, 1, 0, 0, 0};
    lat_tbl[1] = '{0, 1, 0, 0, 0, 0, 0};
    lat_tbl[2] = '{0, 1, 0, 0, 0, 0, 0};
    lat_tbl[3] = '{0, 1, 0, 0, 0, 0, 0};
    lat_tbl[4] = '{0, 1, 0, 0, 1, 23, 1};
    lat_tbl[5] = '{0, 1, 1, 0, 0, 0, 0};

    stall_tbl[0]  = '{1, 1, 0, 1, 0, 0, 0};
    stall_tbl[1]  = '{0, 1, 0, 0, 0, 0, 0};
    stall_tbl[2]  = '{0, 0, 0, 0, 0, 0, 0};
    stall_tbl[3]  = '{1, 0, 0, 0, 0, 0, 0};
    stall_tbl[4]  = '{1, 0, 0, 0, 0, 0, 0};
    stall_tbl[5]  = '{0, 0, 0, 0, 0, 0, 0};
    stall_tbl[6]  = '{0, 0, 0, 0, 0, 0, 0};
    stall_tbl[7]  = '{0, 1, 0, 0, 0, 0, 0};
    stall_tbl[8]  = '{0, 1, 0, 0, 0, 0, 0};
    stall_tbl[9]  = '{0, 1, 0, 0, 1, 23, 1};
    stall_tbl[10] = '{0, 1, 0, 0, 1, 23, 1};
    stall_tbl[11] = '{0, 1, 1, 0, 0, 0, 0};

    // Reset held three cycles with IN_VALID asserted
    set_ops(1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    for (int i = 0; i < LAT + 2; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_no_tags", 64'(count), 64'd0);

    for (int i = 0; i < 6; i++) apply(lat_tbl[i], "latency");
    for (int i = 0; i < 12; i++) apply(stall_tbl[i], "stall");

    // Backpressure: consumer stalled, issue every cycle
    acc_seen = 0;
    for (int i = 0; i < 14; i++) begin
      set_rand_ops();
      if (issue_ready) acc_seen++;
      tick(1'b1, 1'b1, 1'b0, 1'b0);
    end
    check("bp_accepted", 64'(acc_seen), 64'd8);
    check("bp_count_full", 64'(count), 64'd8);
    check("bp_ready_low", 64'(issue_ready), 64'd0);
    check("bp_overflow", 64'(overflow), 64'd1);

    // Drain from full while issuing continuously
    for (int i = 0; i < 20; i++) begin
      set_rand_ops();
      tick(1'b1, 1'b1, 1'b1, 1'b0);
    end
    set_ops(1'b0);
    budget = 0;
    while ((exp_q.size() != 0) && (budget < 60)) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      budget++;
    end
    check("drain_timeout", 64'(budget < 60), 64'd1);
    check("drain_no_loss", 64'(n_pop), 64'(n_acc));
    check("drain_wrapped", 64'(n_pop >= 2 * DEPTH + 2), 64'd1);
    check("drain_empty", 64'(out_valid), 64'd0);

    // Carry out of the post-adder
    a_v = '0; b_v = '0; d_v = '0; c_v = '0;
    pcin_v = 48'hFFFF_FFFF_FFFF;
    op_v = 8'b00110100;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    set_ops(1'b0);
    for (int i = 0; i < LAT; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("carry_valid", 64'(out_valid), 64'd1);
    check("carry_data", 64'(out_data), 64'd0);
`ifdef DSP_COLLECT_CARRY_EN
    check("carry_bit", 64'(out_carry), 64'd1);
`else
    check("carry_bit", 64'(out_carry), 64'd0);
`endif
    tick(1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-flight discards tags and queued results
    for (int i = 0; i < 6; i++) begin
      set_rand_ops();
      tick(1'b1, 1'b1, 1'b0, 1'b0);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(issue_ready), 64'd1);
    check("midrst_overflow", 64'(overflow), 64'd0);
    set_ops(1'b0);
    for (int i = 0; i < LAT + 2; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("midrst_no_stale", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
